ordered_dither_pipe: RTL
========================

ORDERED_DITHER_PIPE -- requirements
Module: ordered_dither_pipe

Interface
REQ-001 Parameter IN_W, 6: input bits per channel.
REQ-002 Parameter OUT_W, 4: output bits per channel; FRAC_W = IN_W-OUT_W SHALL be >= 2*MAT_LOG2.
REQ-003 Parameter NCH, 3: channel count, >= 1.
REQ-004 Parameter MAT_LOG2, 1: log2 of matrix side N; legal values 1 (2x2) and 2 (4x4).
REQ-005 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous, active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 mode  in  2  00 truncate, 01 spatial dither, 10 spatial+temporal dither, 11 round-to-nearest.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-011 in_sof  in  1  beat is first pixel of a frame.
REQ-012 in_x, in_y  in  MAT_LOG2 each  low bits of horizontal/vertical pixel counters.
REQ-013 in_pix  in  NCH*IN_W  channel c at bits [c*IN_W +: IN_W].
REQ-014 out_valid  out  1  output beat valid.
REQ-015 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-016 out_pix  out  NCH*OUT_W  channel c at bits [c*OUT_W +: OUT_W].
REQ-017 frame_cnt  out  2*MAT_LOG2  current temporal phase f.

Function
REQ-018 Each channel splits into I = upper OUT_W bits, F = lower FRAC_W bits.
REQ-019 Matrix M[y][x] for MAT_LOG2=1: row0 = 1,3; row1 = 2,0.
REQ-020 Matrix for MAT_LOG2=2: rows 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5.
REQ-021 Threshold T = M[ye][xe] << (FRAC_W - 2*MAT_LOG2).
REQ-022 Mode 01: xe = in_x, ye = in_y; mode 10: xe = in_x XOR f[MAT_LOG2-1:0], ye = in_y XOR f[2*MAT_LOG2-1:MAT_LOG2].
REQ-023 Modes 01/10: out = I+1 if F > T, else I.
REQ-024 Mode 11: out = I+1 if F >= 2^(FRAC_W-1), else I.
REQ-025 Mode 00: out = I.
REQ-026 Any increment SHALL saturate: I all-ones yields all-ones, never wraps.
REQ-027 All channels of a beat SHALL use the same T; mode SHALL be sampled per accepted beat.
REQ-028 frame_cnt SHALL increment modulo 2^(2*MAT_LOG2) on each accepted beat with in_sof=1, in all modes; that beat and later beats SHALL use the new f.
REQ-029 Pipeline: two register stages (stage 1: inputs, mode, T; stage 2: compare/increment, out_pix); latency from acceptance to out_valid SHALL be 2 cycles with no stall.
REQ-030 in_ready SHALL equal out_ready || !out_valid; a pipeline advance SHALL move both stages together.
REQ-031 Under stall (out_valid && !out_ready) out_pix, out_valid and stage 1 SHALL hold; no beat SHALL be lost, duplicated or reordered.
REQ-032 Bubbles (in_valid=0 on advance) SHALL propagate as out_valid=0.

Reset
REQ-033 rst_n low SHALL immediately clear out_valid, both stage valids, out_pix and frame_cnt to 0.
REQ-034 Beats in flight at reset SHALL be discarded; the first beat accepted after release SHALL appear 2 cycles later.

Verification (defaults: IN_W=6, OUT_W=4, NCH=3, MAT_LOG2=1)
REQ-035 Reset: assert rst_n=0 -> out_valid=0, out_pix=0, frame_cnt=0, with no clock edge required.
REQ-036 Mode 01, channel 0 = 6'b0101_10, (x,y) = (0,0),(1,0),(0,1),(1,1) -> 6,5,5,6; output arrives 2 cycles after each accept.
REQ-037 Saturation: channel 0 = 6'b1111_11 at (1,1) in modes 01 and 11 -> 15; 6'b0111_01 in mode 11 -> 7; 6'b0111_10 in mode 11 -> 8; mode 00 -> 7.
REQ-038 Temporal: mode 10, one sof beat gives f=1; 6'b0101_10 at (0,0) -> 5 (T=3); four sof beats -> frame_cnt wraps to 0.
REQ-039 Backpressure: out_ready=0 for 3 cycles with 2 beats in flight -> out_pix stable, in_ready=0; after release, outputs appear in order with no loss.
REQ-040 Mid-stream reset: pulse rst_n low while out_valid=1 and f=2 -> out_valid=0, f=0; the next beat follows the 2-cycle latency.

Source files
------------

// File: rtl/ordered_dither_pipe.sv
// Ordered (Bayer) dither requantiser, IN_W -> OUT_W bits per channel.
// Two-stage valid/ready pipeline with optional temporal phase rotation.
module ordered_dither_pipe #(
    parameter int IN_W     = 6,
    parameter int OUT_W    = 4,
    parameter int NCH      = 3,
    parameter int MAT_LOG2 = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [MAT_LOG2-1:0]     in_x,
    input  logic [MAT_LOG2-1:0]     in_y,
    input  logic [NCH*IN_W-1:0]     in_pix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCH*OUT_W-1:0]    out_pix,
    output logic [2*MAT_LOG2-1:0]   frame_cnt
);

    localparam int FRAC_W = IN_W - OUT_W;
    localparam int N2     = 2 * MAT_LOG2;
    localparam int SH     = FRAC_W - N2;

    logic [N2-1:0]          r_f;
    logic                   r_s1_valid;
    logic [NCH*IN_W-1:0]    r_s1_pix;
    logic [1:0]             r_s1_mode;
    logic [FRAC_W-1:0]      r_s1_t;
    logic                   r_s2_valid;
    logic [NCH*OUT_W-1:0]   r_out_pix;

    logic                   w_adv;
    logic                   w_acc;
    logic [N2-1:0]          w_f_inc;
    logic [N2-1:0]          w_f;
    logic [MAT_LOG2-1:0]    w_xe;
    logic [MAT_LOG2-1:0]    w_ye;
    logic [N2-1:0]          w_idx;
    logic [N2-1:0]          w_m;
    logic [FRAC_W-1:0]      w_t;
    logic [NCH*OUT_W-1:0]   w_out;

    assign w_adv   = out_ready || !r_s2_valid;
    assign w_acc   = in_valid && w_adv;
    assign w_f_inc = r_f + N2'(1);
    // An sof beat already dithers with the advanced phase.
    assign w_f     = in_sof ? w_f_inc : r_f;

    always_comb begin
        w_xe = in_x;
        w_ye = in_y;
        if (mode == 2'b10) begin
            w_xe = in_x ^ w_f[MAT_LOG2-1:0];
            w_ye = in_y ^ w_f[N2-1:MAT_LOG2];
        end
    end

    assign w_idx = {w_ye, w_xe};

    if (MAT_LOG2 == 1) begin : g_m2
        always_comb begin
            w_m = '0;
            case (w_idx)
                2'd0: w_m = 2'd1;
                2'd1: w_m = 2'd3;
                2'd2: w_m = 2'd2;
                2'd3: w_m = 2'd0;
                default: w_m = '0;
            endcase
        end
    end else begin : g_m4
        always_comb begin
            w_m = '0;
            case (w_idx)
                4'd0:  w_m = 4'd0;
                4'd1:  w_m = 4'd8;
                4'd2:  w_m = 4'd2;
                4'd3:  w_m = 4'd10;
                4'd4:  w_m = 4'd12;
                4'd5:  w_m = 4'd4;
                4'd6:  w_m = 4'd14;
                4'd7:  w_m = 4'd6;
                4'd8:  w_m = 4'd3;
                4'd9:  w_m = 4'd11;
                4'd10: w_m = 4'd1;
                4'd11: w_m = 4'd9;
                4'd12: w_m = 4'd15;
                4'd13: w_m = 4'd7;
                4'd14: w_m = 4'd13;
                4'd15: w_m = 4'd5;
                default: w_m = '0;
            endcase
        end
    end

    assign w_t = FRAC_W'(w_m) << SH;

    always_comb begin
        w_out = '0;
        for (int c = 0; c < NCH; c++) begin : g_ch
            logic [OUT_W-1:0]  w_i;
            logic [FRAC_W-1:0] w_fr;
            logic              w_up;
            w_i  = r_s1_pix[c*IN_W+FRAC_W +: OUT_W];
            w_fr = r_s1_pix[c*IN_W +: FRAC_W];
            w_up = 1'b0;
            unique case (r_s1_mode)
                2'b00: w_up = 1'b0;
                2'b01: w_up = w_fr > r_s1_t;
                2'b10: w_up = w_fr > r_s1_t;
                2'b11: w_up = w_fr[FRAC_W-1];
            endcase
            // Saturate instead of wrapping at full scale.
            if (w_up && !(&w_i))
                w_out[c*OUT_W +: OUT_W] = w_i + OUT_W'(1);
            else
                w_out[c*OUT_W +: OUT_W] = w_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_mode  <= '0;
            r_s1_t     <= '0;
            r_s2_valid <= 1'b0;
            r_out_pix  <= '0;
        end else begin
            if (w_acc && in_sof)
                r_f <= w_f_inc;
            if (w_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_pix  <= in_pix;
                    r_s1_mode <= mode;
                    r_s1_t    <= w_t;
                end
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid)
                    r_out_pix <= w_out;
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_s2_valid;
    assign out_pix   = r_out_pix;
    assign frame_cnt = r_f;

endmodule
